// File: rtl/dense_weight_fetcher.sv
// Read-side sequencer for the dense-layer weight ROM: walks base..base+count-1,
// absorbs the 1-cycle ROM latency and streams zero-point corrected weights.
module dense_weight_fetcher #(
   parameter int NUM_WEIGHT = 507,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int ZERO_POINT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              abort,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W:0]   w_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              w_last,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [DATA_W:0]   ZP       = (DATA_W+1)'(ZERO_POINT);
   localparam logic [ADDR_W+1:0] LIMIT    = (ADDR_W+2)'(NUM_WEIGHT);
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   issue_left_q, issue_left_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        occ_q, occ_d;
   logic [DATA_W:0]   f0_q, f0_d;
   logic [DATA_W:0]   f1_q, f1_d;
   logic              err_q, err_d;

   logic [DATA_W:0]   rd_word;
   logic [ADDR_W+1:0] end_addr;
   logic              range_ok;
   logic              pop;
   logic [1:0]        occ_after;

   // Handshake: a word transfers on every cycle with w_valid & w_ready. Once w_valid
   // is high, w_data/w_last hold until that transfer; only abort drops w_valid early.
   // The word arriving from the ROM is presented directly when the FIFO is empty,
   // which gives the start -> w_valid latency of two cycles.
   assign rd_word   = {1'b0, mem_rdata} - ZP;
   assign end_addr  = {2'b00, base_addr} + {1'b0, count};
   assign range_ok  = (end_addr <= LIMIT);
   assign w_valid   = (occ_q != 2'd0) || inflight_q;
   assign w_data    = (occ_q != 2'd0) ? f0_q : (inflight_q ? rd_word : '0);
   assign w_last    = w_valid && (remain_q == CNT_ONE);
   assign pop       = w_valid && w_ready;
   assign occ_after = occ_q + {1'b0, inflight_q} - {1'b0, pop};
   // A read is only issued if its word is guaranteed a FIFO slot.
   assign mem_en    = (state_q == S_FETCH) && !abort && (occ_after < 2'd2);
   assign mem_addr  = addr_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      remain_d     = remain_q;
      inflight_d   = mem_en;
      occ_d        = occ_after;
      f0_d         = f0_q;
      f1_d         = f1_q;
      err_d        = 1'b0;

      if (pop) begin
         f0_d     = (occ_q == 2'd2) ? f1_q : rd_word;
         remain_d = remain_q - CNT_ONE;
      end else if (inflight_q) begin
         if (occ_q == 2'd0) f0_d = rd_word;
         else               f1_d = rd_word;
      end

      if (mem_en) begin
         issue_left_d = issue_left_q - CNT_ONE;
         if (issue_left_q != CNT_ONE) addr_d = addr_q + ADDR_ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (!range_ok) begin
                  err_d = 1'b1;
               end else if (count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d      = S_FETCH;
                  addr_d       = base_addr;
                  issue_left_d = count;
                  remain_d     = count;
               end
            end
         end
         S_FETCH: begin
            if (abort) begin
               state_d    = S_DONE;
               occ_d      = 2'd0;
               inflight_d = 1'b0;
            end else if (mem_en && (issue_left_q == CNT_ONE)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d    = S_DONE;
               occ_d      = 2'd0;
               inflight_d = 1'b0;
            end else if (pop && (remain_q == CNT_ONE)) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         remain_q     <= '0;
         inflight_q   <= 1'b0;
         occ_q        <= 2'd0;
         f0_q         <= '0;
         f1_q         <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         remain_q     <= remain_d;
         inflight_q   <= inflight_d;
         occ_q        <= occ_d;
         f0_q         <= f0_d;
         f1_q         <= f1_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_dense_weight_fetcher.sv
// Self-checking bench for dense_weight_fetcher: ROM model, expected-word queue
// built from the burst definition, and one task per scenario.
module tb_dense_weight_fetcher;

   localparam int NW = 507;
   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          w_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   count = '0;
   logic [DW-1:0] mem_rdata = '0;

   logic          mem_en, w_valid, w_last, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [DW:0]   w_data;
   logic [1:0]    dbg_state;
   logic          mem_en_z, w_valid_z, w_last_z, busy_z, done_z, err_z;
   logic [AW-1:0] mem_addr_z;
   logic [DW:0]   w_data_z;
   logic [1:0]    dbg_state_z;

   logic [DW-1:0] rom [0:NW-1];
   logic [DW:0]   exp_q [$];
   int            n_checks = 0;
   int            n_errors = 0;

   dense_weight_fetcher #(.NUM_WEIGHT(NW), .ADDR_W(AW), .DATA_W(DW), .ZERO_POINT(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
      .abort(abort), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   dense_weight_fetcher #(.NUM_WEIGHT(NW), .ADDR_W(AW), .DATA_W(DW), .ZERO_POINT(128)) dut_zp (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
      .abort(abort), .mem_en(mem_en_z), .mem_addr(mem_addr_z), .mem_rdata(mem_rdata),
      .w_data(w_data_z), .w_valid(w_valid_z), .w_ready(w_ready), .w_last(w_last_z),
      .busy(busy_z), .done(done_z), .err(err_z), .dbg_state(dbg_state_z)
   );

   // Clock and ROM (registered read, data the cycle after mem_en)
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= (int'(mem_addr) < NW) ? rom[mem_addr] : 8'hEE;
   end

   function automatic logic [DW:0] zp_model(input logic [DW-1:0] v);
      int s;
      s = int'(v) - 128;
      return 9'(s);
   endfunction

   // Scoreboard: every accepted word must be the next expected one; stalled words hold.
   initial begin : scoreboard
      logic          prev_stall;
      logic          prev_abort;
      logic [DW:0]   prev_data;
      logic          prev_last;
      logic [DW:0]   exp_d;
      logic          exp_l;
      prev_stall = 1'b0;
      prev_abort = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && !prev_abort) begin
               n_checks++;
               if (w_valid !== 1'b1 || w_data !== prev_data || w_last !== prev_last) begin
                  n_errors++;
                  $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                           w_valid, w_data, w_last, prev_data, prev_last);
               end
            end
            if (w_valid === 1'b1 && w_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL sb_extra: accepted data=%h, required no word", w_data);
               end else begin
                  exp_d = exp_q.pop_front();
                  exp_l = (exp_q.size() == 0);
                  if (w_data !== exp_d || w_last !== exp_l) begin
                     n_errors++;
                     $display("FAIL sb_word: data=%h last=%b, required data=%h last=%b",
                              w_data, w_last, exp_d, exp_l);
                  end
               end
            end
            prev_stall = (w_valid === 1'b1) && !w_ready;
            prev_data  = w_data;
            prev_last  = w_last;
            prev_abort = abort;
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int b, input int c, input bit load);
      start     = 1'b1;
      base_addr = AW'(b);
      count     = (AW+1)'(c);
      if (load) for (int i = 0; i < c; i++) exp_q.push_back({1'b0, rom[b + i]});
   endtask

   task automatic run_until_done(input int budget, input int ready_pct,
                                 output bit seen, output int issued, output int last_addr);
      seen = 1'b0;
      issued = 0;
      last_addr = -1;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (mem_en) begin
            issued++;
            last_addr = int'(mem_addr);
         end
         if (done) seen = 1'b1;
         tick();
         start = 1'b0;
         w_ready = ($urandom_range(0, 99) < ready_pct);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({mem_en, w_valid, w_last, busy, done, err} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: en/valid/last/busy/done/err=%b, required 000000",
                  {mem_en, w_valid, w_last, busy, done, err});
      end
      n_checks++;
      if (mem_addr !== '0 || w_data !== '0 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_data: addr=%h data=%h state=%0d, required 0 0 0", mem_addr, w_data, dbg_state);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: busy=%b done=%b valid=%b, required 0 0 0", busy, done, w_valid);
      end
   endtask

   task automatic test_basic();
      logic [3:0] got, want;
      for (int i = 0; i < 4; i++) rom[i] = 8'(5 + i);
      w_ready = 1'b1;
      tick();
      launch(0, 4, 1'b1);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         got  = {mem_en, w_valid, done, busy};
         want = {(c >= 1 && c <= 4), (c >= 2 && c <= 5), (c == 6), (c >= 1 && c <= 6)};
         n_checks++;
         if (got !== want) begin
            n_errors++;
            $display("FAIL basic_ctrl cycle %0d: en/valid/done/busy=%b, required %b", c, got, want);
         end
         if (c >= 1 && c <= 4) begin
            n_checks++;
            if (mem_addr !== AW'(c - 1)) begin
               n_errors++;
               $display("FAIL basic_addr cycle %0d: addr=%0d, required %0d", c, mem_addr, c - 1);
            end
         end
         if (c >= 2 && c <= 5) begin
            n_checks++;
            if (w_data !== 9'(5 + c - 2) || w_last !== (c == 5)) begin
               n_errors++;
               $display("FAIL basic_data cycle %0d: data=%0d last=%b, required %0d %b",
                        c, w_data, w_last, 5 + c - 2, (c == 5));
            end
         end
         tick();
         start = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL basic_drain: %0d words left, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      bit pat [0:5];
      int issued, acc;
      bit seen;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      issued = 0;
      acc = 0;
      seen = 1'b0;
      w_ready = pat[0];
      tick();
      launch(100, 6, 1'b1);
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (mem_en) begin
            issued++;
            n_checks++;
            if (mem_addr !== AW'(100 + issued - 1)) begin
               n_errors++;
               $display("FAIL bp_addr: addr=%0d, required %0d", mem_addr, 100 + issued - 1);
            end
         end
         if (w_valid && w_ready) acc++;
         n_checks++;
         if (issued - acc > 2) begin
            n_errors++;
            $display("FAIL bp_bound: outstanding=%0d, required <=2", issued - acc);
         end
         if (done) seen = 1'b1;
         tick();
         start = 1'b0;
         if (k + 1 < 6) w_ready = pat[k + 1];
         else           w_ready = 1'($urandom_range(0, 1));
      end
      n_checks++;
      if (!seen || acc != 6 || issued != 6 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL bp_total: done=%b accepted=%0d issued=%0d left=%0d, required 1 6 6 0",
                  seen, acc, issued, exp_q.size());
      end
   endtask

   task automatic test_range();
      bit seen;
      int issued, last_addr;
      w_ready = 1'b1;
      tick();
      launch(500, 8, 1'b0);
      tick();
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
         n_errors++;
         $display("FAIL range_err: err=%b busy=%b en=%b, required 1 0 0", err, busy, mem_en);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
         n_errors++;
         $display("FAIL range_pulse: err=%b busy=%b en=%b, required 0 0 0", err, busy, mem_en);
      end
      tick();
      launch(499, 8, 1'b1);
      run_until_done(100, 100, seen, issued, last_addr);
      n_checks++;
      if (!seen || issued != 8 || last_addr != 506 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL range_edge: done=%b issued=%0d last_addr=%0d left=%0d, required 1 8 506 0",
                  seen, issued, last_addr, exp_q.size());
      end
   endtask

   task automatic test_empty();
      tick();
      launch(50, 0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (mem_en !== 1'b0 || w_valid !== 1'b0 || done !== (c == 1) || busy !== (c == 1)) begin
            n_errors++;
            $display("FAIL empty cycle %0d: en=%b valid=%b done=%b busy=%b, required 0 0 %b %b",
                     c, mem_en, w_valid, done, busy, (c == 1), (c == 1));
         end
         tick();
         start = 1'b0;
      end
   endtask

   task automatic test_abort();
      int acc, stall, issued, last_addr;
      bit aborted, seen;
      acc = 0;
      stall = 0;
      aborted = 1'b0;
      w_ready = 1'b1;
      tick();
      launch(10, 10, 1'b1);
      for (int k = 0; k < 60 && !aborted; k++) begin
         @(negedge clk);
         if (w_valid && w_ready) acc++;
         if (k == 4) begin
            n_checks++;
            if (err !== 1'b0) begin
               n_errors++;
               $display("FAIL busy_start: err=%b, required 0", err);
            end
         end
         if (abort) aborted = 1'b1;
         tick();
         start = (k == 2);
         if (k == 2) begin
            base_addr = AW'(300);
            count     = (AW+1)'(5);
         end
         w_ready = (acc < 3);
         if (acc >= 3) stall++;
         abort = (stall == 3);
      end
      abort = 1'b0;
      n_checks++;
      if (!aborted || acc != 3 || exp_q.size() != 7) begin
         n_errors++;
         $display("FAIL abort_setup: aborted=%b accepted=%0d left=%0d, required 1 3 7",
                  aborted, acc, exp_q.size());
      end
      @(negedge clk);
      n_checks++;
      if (w_valid !== 1'b0 || done !== 1'b1 || mem_en !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_flush: valid=%b done=%b en=%b, required 0 1 0", w_valid, done, mem_en);
      end
      exp_q.delete();
      tick();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy, done);
      end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_in_idle: busy=%b done=%b, required 0 0", busy, done);
      end
      w_ready = 1'b1;
      tick();
      launch(20, 3, 1'b1);
      run_until_done(50, 100, seen, issued, last_addr);
      n_checks++;
      if (!seen || issued != 3 || last_addr != 22 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL abort_restart: done=%b issued=%0d last_addr=%0d left=%0d, required 1 3 22 0",
                  seen, issued, last_addr, exp_q.size());
      end
   endtask

   task automatic test_zero_point();
      rom[200] = 8'h00;
      rom[201] = 8'hFF;
      w_ready = 1'b1;
      tick();
      launch(200, 2, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 2) begin
            n_checks++;
            if (w_valid_z !== 1'b1 || w_data_z !== zp_model(rom[200]) || w_last_z !== 1'b0) begin
               n_errors++;
               $display("FAIL zp_low: valid=%b data=%h last=%b, required 1 %h 0",
                        w_valid_z, w_data_z, w_last_z, zp_model(rom[200]));
            end
         end
         if (c == 3) begin
            n_checks++;
            if (w_valid_z !== 1'b1 || w_data_z !== zp_model(rom[201]) || w_last_z !== 1'b1) begin
               n_errors++;
               $display("FAIL zp_high: valid=%b data=%h last=%b, required 1 %h 1",
                        w_valid_z, w_data_z, w_last_z, zp_model(rom[201]));
            end
         end
         tick();
         start = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL zp_drain: %0d words left, required 0", exp_q.size());
      end
      tick();
      launch(300, 20, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tick();
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_en, w_valid, w_last, busy, done, err} !== 6'b0 || mem_addr !== '0 || w_data !== '0) begin
         n_errors++;
         $display("FAIL rst_mid: en/valid/last/busy/done/err=%b addr=%h data=%h, required all 0",
                  {mem_en, w_valid, w_last, busy, done, err}, mem_addr, w_data);
      end
      n_checks++;
      if ({mem_en_z, w_valid_z, w_last_z, busy_z, done_z, err_z} !== 6'b0 || mem_addr_z !== '0 ||
          w_data_z !== '0) begin
         n_errors++;
         $display("FAIL rst_mid_zp: ctrl=%b addr=%h data=%h, required all 0",
                  {mem_en_z, w_valid_z, w_last_z, busy_z, done_z, err_z}, mem_addr_z, w_data_z);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_after cycle %0d: busy=%b done=%b valid=%b state=%0d, required 0 0 0 0",
                     c, busy, done, w_valid, dbg_state);
         end
         tick();
      end
   endtask

   task automatic test_random_bursts();
      int b, c, maxc, issued, last_addr;
      bit seen;
      for (int n = 0; n < 6; n++) begin
         b = $urandom_range(0, NW - 1);
         maxc = NW - b;
         if (maxc > 32) maxc = 32;
         c = $urandom_range(1, maxc);
         w_ready = 1'($urandom_range(0, 1));
         tick();
         launch(b, c, 1'b1);
         run_until_done(600, 60, seen, issued, last_addr);
         n_checks++;
         if (!seen || issued != c || last_addr != b + c - 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rand_burst base=%0d count=%0d: done=%b issued=%0d last_addr=%0d left=%0d, required 1 %0d %0d 0",
                     b, c, seen, issued, last_addr, exp_q.size(), c, b + c - 1);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) rom[i] = 8'($urandom_range(0, 255));
      test_reset();
      test_basic();
      test_backpressure();
      test_range();
      test_empty();
      test_abort();
      test_zero_point();
      test_random_bursts();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
